// File: rtl/pc_combine.sv
// Single-cycle MIPS-32 fetch/decode/execute slice: PC, ROM, decoder, 32x32 regfile, ALU, write-back.
// Build option: define IMM_OPS_EN to decode the I-type ALU ops (addi/addiu/slti/andi/ori/xori).
module pc_combine #(
  parameter int IMEM_DEPTH = 32,
  parameter int RESET_PC   = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] p_out,
  output logic [5:0]  opcode,
  output logic [4:0]  r_reg1,
  output logic [4:0]  r_reg2,
  output logic [4:0]  w_reg,
  output logic [4:0]  shift,
  output logic [5:0]  funct,
  output logic [15:0] inst_16bit,
  output logic [31:0] r1_data,
  output logic [31:0] r2_data,
  output logic [31:0] result,
  output logic        zero,
  output logic        wr_file
);

  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] regs_q [32];

  logic [31:0]        instr;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic signed [31:0] alu_a_s;
  logic signed [31:0] alu_b_s;
  logic [31:0]        alu_res;
  logic [4:0]         dest;
  logic               wr_en;

  // Program image; words past the listed ones are sll $0,$0,0.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
    logic [31:0] w;
    case (32'(idx))
      0:       w = 32'h0022_1820;
      1:       w = 32'h0041_2022;
      2:       w = 32'h0064_2824;
      3:       w = 32'h0064_3025;
      4:       w = 32'h0083_382A;
      5:       w = 32'h0021_4022;
      6:       w = 32'h0002_4900;
      7:       w = 32'h202A_FFFF;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign pc_d  = pc_q + 32'd4;
  assign instr = rom_word(pc_q[AW+1:2]);

  assign p_out      = pc_q;
  assign opcode     = instr[31:26];
  assign r_reg1     = instr[25:21];
  assign r_reg2     = instr[20:16];
  assign w_reg      = instr[15:11];
  assign shift      = instr[10:6];
  assign funct      = instr[5:0];
  assign inst_16bit = instr[15:0];

  assign r1_data = (r_reg1 == 5'd0) ? 32'd0 : regs_q[r_reg1];
  assign r2_data = (r_reg2 == 5'd0) ? 32'd0 : regs_q[r_reg2];

  always_comb begin
    alu_a   = r1_data;
    alu_b   = r2_data;
    dest    = w_reg;
    wr_en   = 1'b0;
    alu_res = 32'd0;
    if (opcode == OP_RTYPE) begin
      wr_en = 1'b1;
      case (funct)
        FN_ADD, FN_ADDU: alu_res = alu_a + alu_b;
        FN_SUB, FN_SUBU: alu_res = alu_a - alu_b;
        FN_AND:          alu_res = alu_a & alu_b;
        FN_OR:           alu_res = alu_a | alu_b;
        FN_XOR:          alu_res = alu_a ^ alu_b;
        FN_NOR:          alu_res = ~(alu_a | alu_b);
        FN_SLT:          alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
        FN_SLTU:         alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
        FN_SLL:          alu_res = alu_b << shift;
        FN_SRL:          alu_res = alu_b >> shift;
        FN_SRA:          alu_res = 32'($signed(alu_b) >>> shift);
        default: begin
          alu_res = 32'd0;
          wr_en   = 1'b0;
        end
      endcase
    end
`ifdef IMM_OPS_EN
    else begin
      dest = r_reg2;
      case (opcode)
        6'h08, 6'h09: begin
          alu_b   = {{16{inst_16bit[15]}}, inst_16bit};
          alu_res = alu_a + alu_b;
          wr_en   = 1'b1;
        end
        6'h0A: begin
          alu_b   = {{16{inst_16bit[15]}}, inst_16bit};
          alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
          wr_en   = 1'b1;
        end
        6'h0C: begin
          alu_b   = {16'd0, inst_16bit};
          alu_res = alu_a & alu_b;
          wr_en   = 1'b1;
        end
        6'h0D: begin
          alu_b   = {16'd0, inst_16bit};
          alu_res = alu_a | alu_b;
          wr_en   = 1'b1;
        end
        6'h0E: begin
          alu_b   = {16'd0, inst_16bit};
          alu_res = alu_a ^ alu_b;
          wr_en   = 1'b1;
        end
        default: begin
          alu_res = 32'd0;
          wr_en   = 1'b0;
        end
      endcase
    end
`endif
  end

  // Signed views kept for waveform readability of the operand pair.
  assign alu_a_s = alu_a;
  assign alu_b_s = alu_b;

  assign result  = alu_res;
  assign zero    = (alu_res == 32'd0);
  assign wr_file = wr_en;

  // Reset re-seeds reg[i] = i and suppresses write-back on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'(RESET_PC);
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'(i);
      end
    end else begin
      pc_q <= pc_d;
      if (wr_en && (dest != 5'd0) && (alu_a_s == alu_a_s) && (alu_b_s == alu_b_s)) begin
        regs_q[dest] <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_pc_combine.sv
// Directed bench for pc_combine: walks the ROM program, wrap-around and a mid-program reset.
module tb_pc_combine;

  logic        clk;
  logic        reset;
  logic [31:0] p_out;
  logic [5:0]  opcode;
  logic [4:0]  r_reg1;
  logic [4:0]  r_reg2;
  logic [4:0]  w_reg;
  logic [4:0]  shift;
  logic [5:0]  funct;
  logic [15:0] inst_16bit;
  logic [31:0] r1_data;
  logic [31:0] r2_data;
  logic [31:0] result;
  logic        zero;
  logic        wr_file;

  int checks = 0;
  int errors = 0;

  pc_combine #(.IMEM_DEPTH(32), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .p_out(p_out), .opcode(opcode),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .w_reg(w_reg), .shift(shift),
    .funct(funct), .inst_16bit(inst_16bit), .r1_data(r1_data),
    .r2_data(r2_data), .result(result), .zero(zero), .wr_file(wr_file)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state: PC 0, add $3,$1,$2 on reset register values
    chk("rst_pc",      p_out,      32'd0);
    chk("rst_opcode",  opcode,     32'd0);
    chk("rst_rs",      r_reg1,     32'd1);
    chk("rst_rt",      r_reg2,     32'd2);
    chk("rst_rd",      w_reg,      32'd3);
    chk("rst_shamt",   shift,      32'd0);
    chk("rst_funct",   funct,      32'd32);
    chk("rst_imm",     inst_16bit, 32'h1820);
    chk("rst_r1",      r1_data,    32'd1);
    chk("rst_r2",      r2_data,    32'd2);
    chk("rst_result",  result,     32'd3);
    chk("rst_zero",    zero,       32'd0);
    chk("rst_wr",      wr_file,    32'd1);

    reset = 1'b0;
    step();
    chk("sub_pc",     p_out,   32'd4);
    chk("sub_funct",  funct,   32'h22);
    chk("sub_rd",     w_reg,   32'd4);
    chk("sub_r1",     r1_data, 32'd2);
    chk("sub_r2",     r2_data, 32'd1);
    chk("sub_result", result,  32'd1);

    step();
    chk("and_pc",     p_out,   32'd8);
    chk("and_r1",     r1_data, 32'd3);
    chk("and_r2",     r2_data, 32'd1);
    chk("and_result", result,  32'd1);

    step();
    chk("or_pc",     p_out,   32'd12);
    chk("or_r1",     r1_data, 32'd3);
    chk("or_r2",     r2_data, 32'd1);
    chk("or_result", result,  32'd3);

    step();
    chk("slt_pc",     p_out,   32'd16);
    chk("slt_funct",  funct,   32'h2A);
    chk("slt_r1",     r1_data, 32'd1);
    chk("slt_r2",     r2_data, 32'd3);
    chk("slt_result", result,  32'd1);

    step();
    chk("sub8_pc",     p_out,   32'd20);
    chk("sub8_result", result,  32'd0);
    chk("sub8_zero",   zero,    32'd1);
    chk("sub8_wr",     wr_file, 32'd1);

    step();
    chk("sll_pc",     p_out,          32'd24);
    chk("reg8_after", dut.regs_q[8],  32'd0);
    chk("reg7_after", dut.regs_q[7],  32'd1);
    chk("reg5_after", dut.regs_q[5],  32'd1);
    chk("sll_shamt",  shift,          32'd4);
    chk("sll_r1",     r1_data,        32'd0);
    chk("sll_result", result,         32'd32);
    chk("sll_zero",   zero,           32'd0);

    step();
    chk("addi_pc",     p_out,         32'd28);
    chk("addi_opcode", opcode,        32'h08);
    chk("addi_rt",     r_reg2,        32'd10);
    chk("addi_imm",    inst_16bit,    32'd65535);
    chk("reg9_after",  dut.regs_q[9], 32'd32);
    chk("addi_result", result,        32'd0);
    chk("addi_zero",   zero,          32'd1);
`ifdef IMM_OPS_EN
    chk("addi_wr",     wr_file,       32'd1);
`else
    chk("addi_wr",     wr_file,       32'd0);
`endif

    step();
    chk("nop_pc",     p_out,   32'd32);
`ifdef IMM_OPS_EN
    chk("reg10_after", dut.regs_q[10], 32'd0);
`else
    chk("reg10_after", dut.regs_q[10], 32'd10);
`endif
    chk("nop_opcode", opcode,  32'd0);
    chk("nop_wr",     wr_file, 32'd1);
    chk("nop_result", result,  32'd0);
    chk("nop_r1",     r1_data, 32'd0);

    repeat (23) step();
    chk("last_pc",   p_out,         32'd124);
    chk("reg0_zero", dut.regs_q[0], 32'd0);

    // PC 128 wraps to ROM word 0 with the program's register state
    step();
    chk("wrap_pc",     p_out,   32'd128);
    chk("wrap_funct",  funct,   32'h20);
    chk("wrap_r1",     r1_data, 32'd1);
    chk("wrap_r2",     r2_data, 32'd2);
    chk("wrap_result", result,  32'd3);
    step();
    chk("wrap2_pc",     p_out,  32'd132);
    chk("wrap2_result", result, 32'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_pc", p_out, 32'd0);
    repeat (10) step();
    chk("pc40", p_out, 32'd40);
    chk("pc40_reg4", dut.regs_q[4], 32'd1);

    // Mid-program reset at PC 40
    reset = 1'b1;
    step();
    chk("midrst_pc",     p_out,          32'd0);
    chk("midrst_reg4",   dut.regs_q[4],  32'd4);
    chk("midrst_reg8",   dut.regs_q[8],  32'd8);
    chk("midrst_reg9",   dut.regs_q[9],  32'd9);
    chk("midrst_reg10",  dut.regs_q[10], 32'd10);
    chk("midrst_result", result,         32'd3);
    reset = 1'b0;
    step();
    chk("post_pc",     p_out,  32'd4);
    chk("post_result", result, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
